// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, buffers {pc, inst} pairs from a
// combinational ROM in a small prefetch FIFO, and hands them to decode over valid/ready.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] HALT_INST  = 32'h0000_0063
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        halted,
  output logic [31:0] retired_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               halted_q, halted_d;
  logic [31:0]        retired_q, retired_d;

  logic               pop;
  logic               push;
  logic               full;
  logic               halt_pop;
  entry_t             head;

  // Outputs are taken straight from state registers, so nothing on imem_inst or
  // out_ready can reach out_* within the same cycle.
  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (count_q != '0);
  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign halted      = halted_q;
  assign retired_cnt = retired_q;
  assign imem_addr   = fetch_pc_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    retired_d  = retired_q;

    pop      = out_valid & out_ready;
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    push     = fetch_en & ~halted_q & ~redirect_valid & (~full | pop);
    halt_pop = pop & ~redirect_valid & (head.inst == HALT_INST);

    // A pop in a redirect or halting cycle still retires before the flush.
    if (pop) begin
      retired_d = retired_q + 32'd1;
    end

    if (redirect_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc & ~32'h3;
      halted_d   = 1'b0;
    end else if (halt_pop) begin
      // Halting drops the rest of the FIFO and leaves fetch_pc where it was.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      halted_d = 1'b1;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: fetch_pc_q, inst: imem_inst};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        fetch_pc_d      = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the FIFO storage is reset too, because out_pc/out_inst read it directly
      // and must show 0 straight out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
    end
  end

endmodule
